wb_host_master: RTL

- Wishbone B3 master that sits directly upstream of the SDRAM controller's Wishbone slave port.
- Converts a simple host command/response interface into compliant Wishbone cycles:
  - single-beat classic reads and writes;
  - incrementing read bursts (CTI 3'b010 / 3'b111).
- Guarantees known outputs during reset, STB identical to CYC, and one response per acknowledged beat.

---
 rtl/wb_host_master_if.sv | 48 ++++
 rtl/wb_host_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_host_master_if.sv
// Host command/response and Wishbone B3 master signal bundle for wb_host_master.
// The master modport is the block's view; the slave modport is the view of whatever surrounds it.
interface wb_host_master_if #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
);
  localparam int SW = DW / 8;
  localparam int LW = $clog2(MAX_BURST) + 1;

  // Host command: accepted on a rising edge where cmd_valid && cmd_ready.
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_sel;
  logic [LW-1:0] cmd_len;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          rsp_err;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, cmd_len,
    input  wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, cmd_len,
    output wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone B3 master: host commands become classic single beats or incrementing read bursts.
// Define WB_MASTER_TIMEOUT_EN to add the no-ACK watchdog that aborts a stalled cycle with rsp_err.
module wb_host_master #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_host_master_if.master  bus,
  output logic [1:0]        o_dbg_state
);
  localparam int SW = DW / 8;
  localparam int LW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_sel;
  logic [LW-1:0] r_remain;
  logic          r_burst;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_last;

  logic          w_cmd_ready;
  logic          w_accept;
  logic          w_cyc;
  logic          w_ack;
  logic          w_final;
  logic          w_timeout;
  logic [LW-1:0] w_len_eff;
  logic [2:0]    w_cti;

  assign w_cmd_ready = (r_state == ST_IDLE) && !wb_rst_i;
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_cyc       = (r_state == ST_BUS);
  assign w_ack       = w_cyc && bus.wb_ack_i;
  assign w_final     = w_ack && (r_remain == LW'(1));

  // Writes are always single-beat; reads clamp to 1..MAX_BURST.
  always_comb begin
    w_len_eff = bus.cmd_len;
    if (bus.cmd_we || (bus.cmd_len == '0)) begin
      w_len_eff = LW'(1);
    end else if (bus.cmd_len > LW'(MAX_BURST)) begin
      w_len_eff = LW'(MAX_BURST);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUS;
      ST_BUS:  if (w_final || w_timeout) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_remain    <= '0;
      r_burst     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
      if (w_accept) begin
        r_we     <= bus.cmd_we;
        r_addr   <= bus.cmd_addr;
        r_wdata  <= bus.cmd_wdata;
        r_sel    <= bus.cmd_sel;
        r_remain <= w_len_eff;
        r_burst  <= (w_len_eff != LW'(1));
      end
      if (w_ack) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_we ? '0 : bus.wb_dat_i;
        r_rsp_last  <= (r_remain == LW'(1));
        r_addr      <= r_addr + AW'(SW);
        r_remain    <= r_remain - LW'(1);
      end
      // Abort: a single error response closes the command, remaining beats dropped.
      if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_last  <= 1'b1;
        r_remain    <= '0;
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_rsp_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
    end else if (!w_cyc || bus.wb_ack_i) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_timeout = w_cyc && !bus.wb_ack_i && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_timeout;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  // Never true; keeps TIMEOUT_CYC referenced when the watchdog is absent.
  assign w_timeout   = (TIMEOUT_CYC < 0);
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    w_cti = 3'b000;
    if (w_cyc && r_burst) begin
      w_cti = (r_remain == LW'(1)) ? 3'b111 : 3'b010;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_last  = r_rsp_last;

  // Bus outputs are qualified by cyc so they read 0 whenever no cycle is open.
  assign bus.wb_cyc_o  = w_cyc;
  assign bus.wb_stb_o  = w_cyc;
  assign bus.wb_we_o   = w_cyc && r_we;
  assign bus.wb_addr_o = w_cyc ? r_addr : '0;
  assign bus.wb_dat_o  = (w_cyc && r_we) ? r_wdata : '0;
  assign bus.wb_sel_o  = w_cyc ? r_sel : '0;
  assign bus.wb_cti_o  = w_cti;

  assign o_dbg_state = r_state;
endmodule
